// File: rtl/bomb_pkg.sv
// Shared types and constants for the "BOMB" keyword scan scheduler.
package bomb_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } prog_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_SAVE = 2'd2
    } fsm_t;

    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CH_O = 8'h4F;
    localparam logic [7:0] CH_M = 8'h4D;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ACNT_W = 8;

endpackage

// File: rtl/bomb_scan_sched_if.sv
// Requester/alert bus between the ASCII receivers and the shared keyword scheduler.
interface bomb_scan_sched_if #(
    parameter int unsigned NCH = 4
) ();
    localparam int unsigned CHW = $clog2(NCH);

    logic [NCH-1:0]   req_valid;
    logic [8*NCH-1:0] req_byte;
    logic [NCH-1:0]   req_ready;
    logic [NCH-1:0]   grant;
    logic             busy;
    logic             alert;
    logic [CHW-1:0]   alert_ch;
    logic [8*NCH-1:0] alert_cnt;

    modport master (
        output req_valid, req_byte,
        input  req_ready, grant, busy, alert, alert_ch, alert_cnt
    );

    modport slave (
        input  req_valid, req_byte,
        output req_ready, grant, busy, alert, alert_ch, alert_cnt
    );
endinterface

// File: rtl/bomb_scan_sched_step.sv
// One matcher step: advances "BOMB" progress by a single byte, flags completion.
module bomb_step
    import bomb_pkg::*;
(
    input  prog_t       prog_in,
    input  logic [7:0]  byte_in,
    output prog_t       prog_out,
    output logic        hit
);

    always_comb begin
        prog_out = S0;
        hit      = 1'b0;
        case (prog_in)
            S0: if (byte_in == CH_B) prog_out = S1;
            S1: begin
                if (byte_in == CH_O)      prog_out = S2;
                else if (byte_in == CH_B) prog_out = S1;
            end
            S2: begin
                if (byte_in == CH_M)      prog_out = S3;
                else if (byte_in == CH_B) prog_out = S1;
            end
            S3: begin
                // trailing 'B' both completes the keyword and starts the next one
                if (byte_in == CH_B) begin
                    prog_out = S1;
                    hit      = 1'b1;
                end
            end
            default: prog_out = S0;
        endcase
    end

endmodule

// File: rtl/bomb_scan_sched.sv
// Round-robin sharing of one "BOMB" matcher across NCH byte streams with per-channel context.
// Optional per-channel saturating alert counters when BSS_ALERT_CNT_EN is defined.
module bomb_scan_sched
    import bomb_pkg::*;
#(
    parameter int unsigned NCH   = 4,
    parameter int unsigned BURST = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    bomb_scan_sched_if.slave     bus
);

    localparam int unsigned CHW = $clog2(NCH);

    fsm_t             state_q, state_d;
    logic [NCH-1:0]   grant_q, grant_d;
    logic [CHW-1:0]   gidx_q, gidx_d;
    logic [CHW-1:0]   last_q, last_d;
    prog_t            prog_q, prog_d;
    prog_t            ctx_q [NCH];
    prog_t            ctx_d [NCH];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             alert_q, alert_d;
    logic [CHW-1:0]   alert_ch_q, alert_ch_d;
    logic             busy_q, busy_d;

    logic [7:0]       byte_arr [NCH];
    logic [7:0]       cur_byte_c;
    logic             take_c;
    logic [CHW-1:0]   winner_c;
    prog_t            step_prog_c;
    logic             step_hit_c;

    for (genvar i = 0; i < NCH; i++) begin : g_unpack
        assign byte_arr[i] = bus.req_byte[8*i +: 8];
    end

    assign cur_byte_c = byte_arr[gidx_q];
    assign take_c     = (state_q == ST_SCAN) && bus.req_valid[gidx_q];

    bomb_step u_step (
        .prog_in  (prog_q),
        .byte_in  (cur_byte_c),
        .prog_out (step_prog_c),
        .hit      (step_hit_c)
    );

    // First requesting channel strictly after last_q, wrapping around.
    always_comb begin
        logic           found;
        logic [CHW-1:0] idx;
        found    = 1'b0;
        winner_c = '0;
        idx      = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = CHW'((32'(last_q) + k) % NCH);
            if (!found && bus.req_valid[idx]) begin
                found    = 1'b1;
                winner_c = idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        last_d     = last_q;
        prog_d     = prog_q;
        cnt_d      = cnt_q;
        ctx_d      = ctx_q;
        alert_d    = 1'b0;
        alert_ch_d = alert_ch_q;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    grant_d = NCH'(1) << winner_c;
                    gidx_d  = winner_c;
                    prog_d  = ctx_q[winner_c];
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (take_c) begin
                    prog_d = step_prog_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (step_hit_c) begin
                        alert_d    = 1'b1;
                        alert_ch_d = gidx_q;
                    end
                    if (cnt_q == CNT_W'(BURST - 1)) state_d = ST_SAVE;
                end else begin
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                ctx_d[gidx_q] = prog_q;
                last_d        = gidx_q;
                grant_d       = '0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            last_q     <= CHW'(NCH - 1);
            prog_q     <= S0;
            cnt_q      <= '0;
            alert_q    <= 1'b0;
            alert_ch_q <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) ctx_q[i] <= S0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            last_q     <= last_d;
            prog_q     <= prog_d;
            cnt_q      <= cnt_d;
            alert_q    <= alert_d;
            alert_ch_q <= alert_ch_d;
            busy_q     <= busy_d;
            ctx_q      <= ctx_d;
        end
    end

    // Ready is gated by rst so a byte presented during reset is never consumed.
    assign bus.req_ready = ((state_q == ST_SCAN) && !rst) ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.alert     = alert_q;
    assign bus.alert_ch  = alert_ch_q;

`ifdef BSS_ALERT_CNT_EN
    logic [ACNT_W-1:0] acnt_q [NCH];
    logic [ACNT_W-1:0] acnt_d [NCH];

    always_comb begin
        acnt_d = acnt_q;
        if (alert_d && (acnt_q[alert_ch_d] != {ACNT_W{1'b1}}))
            acnt_d[alert_ch_d] = acnt_q[alert_ch_d] + ACNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) acnt_q[i] <= '0;
        end else begin
            acnt_q <= acnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_acnt
        assign bus.alert_cnt[8*i +: 8] = acnt_q[i];
    end
`else
    assign bus.alert_cnt = '0;
`endif

endmodule

// File: tb/tb_bomb_scan_sched.sv
// Directed bench for bomb_scan_sched (NCH=4/BURST=8 plus an NCH=2/BURST=1 instance).
module tb_bomb_scan_sched;
    import bomb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_alerts = 0;
    int ch_alerts [4];
    logic [1:0] last_alert_ch;

    logic [3:0] tb_valid;
    logic [7:0] tb_byte [4];
    logic [1:0] tb1_valid;

    bomb_scan_sched_if #(.NCH(4)) bus ();
    bomb_scan_sched_if #(.NCH(2)) bus1 ();

    assign bus.req_valid = tb_valid;
    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign bus.req_byte[8*i +: 8] = tb_byte[i];
    end
    assign bus1.req_valid = tb1_valid;
    assign bus1.req_byte  = {8'h51, 8'h42};

    bomb_scan_sched #(.NCH(4), .BURST(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bomb_scan_sched #(.NCH(2), .BURST(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // alert is a one-cycle pulse, so one negedge sample per pulse
    always @(negedge clk) begin
        if (bus.alert === 1'b1) begin
            n_alerts++;
            ch_alerts[bus.alert_ch]++;
            last_alert_ch = bus.alert_ch;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [1:0] ch, input logic [7:0] b);
        logic done;
        done        = 1'b0;
        tb_valid[ch] = 1'b1;
        tb_byte[ch]  = b;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (bus.req_ready[ch] === 1'b1) done = 1'b1;
        end
        chk("byte_accepted", 64'(done), 64'(1));
        if (done) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input logic [1:0] ch, input string s);
        for (int i = 0; i < s.len(); i++) send_byte(ch, s[i]);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0;
        int c0;
        int c1;
        int ph;
        int ch;
        int ph1;
        int ch1;

        for (int i = 0; i < 4; i++) begin
            tb_byte[i]   = 8'h00;
            ch_alerts[i] = 0;
        end
        last_alert_ch = '0;
        tb_valid  = 4'hF;
        tb1_valid = 2'b00;
        rst       = 1'b1;

        // reset state, with requests pending to show nothing is granted
        cycles(2);
        chk("rst_grant",    64'(bus.grant),     64'(0));
        chk("rst_ready",    64'(bus.req_ready), 64'(0));
        chk("rst_alert",    64'(bus.alert),     64'(0));
        chk("rst_alert_ch", 64'(bus.alert_ch),  64'(0));
        chk("rst_busy",     64'(bus.busy),      64'(0));
        chk("rst_acnt",     64'(bus.alert_cnt), 64'(0));
        tb_valid = 4'h0;
        rst      = 1'b0;
        cycles(1);

        // 1: "BOMB" on ch0
        a0 = n_alerts;
        send_str(2'd0, "BOMB");
        chk("t1_alert",    64'(bus.alert),    64'(1));
        chk("t1_alert_ch", 64'(bus.alert_ch), 64'(0));
        tb_valid[0] = 1'b0;
        cycles(1);
        chk("t1_alert_pulse", 64'(bus.alert), 64'(0));
        cycles(3);
        chk("t1_alert_count", 64'(n_alerts - a0), 64'(1));

        // 2: keyword split across grants with ch1 traffic between
        a0 = n_alerts;
        c1 = ch_alerts[1];
        send_str(2'd0, "BO");
        tb_valid[0] = 1'b0;
        send_str(2'd1, "X");
        tb_valid[1] = 1'b0;
        send_str(2'd0, "MB");
        chk("t2_alert",    64'(bus.alert),    64'(1));
        chk("t2_alert_ch", 64'(bus.alert_ch), 64'(0));
        tb_valid[0] = 1'b0;
        cycles(4);
        chk("t2_alert_count", 64'(n_alerts - a0),      64'(1));
        chk("t2_ch1_quiet",   64'(ch_alerts[1] - c1),  64'(0));

        // 3 (and BURST=1 instance): all channels valid, round-robin from reset
        rst       = 1'b1;
        tb_valid  = 4'hF;
        tb1_valid = 2'b11;
        for (int i = 0; i < 4; i++) tb_byte[i] = 8'h41;
        cycles(1);
        chk("t3_ready_in_rst",  64'(bus.req_ready),  64'(0));
        chk("t3_ready1_in_rst", 64'(bus1.req_ready), 64'(0));
        rst = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk);
            @(negedge clk);
            ph  = (k - 1) % 10;
            ch  = ((k - 1) / 10) % 4;
            chk($sformatf("t3_grant_k%0d", k), 64'(bus.grant),
                (ph <= 8) ? (64'(1) << ch) : 64'(0));
            chk($sformatf("t3_ready_k%0d", k), 64'(bus.req_ready),
                (ph <= 7) ? (64'(1) << ch) : 64'(0));
            chk($sformatf("t3_busy_k%0d", k), 64'(bus.busy),
                (ph <= 8) ? 64'(1) : 64'(0));
            ph1 = (k - 1) % 3;
            ch1 = ((k - 1) / 3) % 2;
            chk($sformatf("b1_grant_k%0d", k), 64'(bus1.grant),
                (ph1 <= 1) ? (64'(1) << ch1) : 64'(0));
            chk($sformatf("b1_ready_k%0d", k), 64'(bus1.req_ready),
                (ph1 == 0) ? (64'(1) << ch1) : 64'(0));
        end
        tb_valid  = 4'h0;
        tb1_valid = 2'b00;
        cycles(4);
        chk("t3_idle_grant", 64'(bus.grant), 64'(0));
        chk("b1_no_alert",   64'(bus1.alert), 64'(0));

        // 4: overlapping keywords on ch2
        a0 = n_alerts;
        c0 = ch_alerts[2];
        send_str(2'd2, "BOMBOMB");
        chk("t4_alert",    64'(bus.alert),    64'(1));
        chk("t4_alert_ch", 64'(bus.alert_ch), 64'(2));
        tb_valid[2] = 1'b0;
        cycles(4);
        chk("t4_alert_count", 64'(n_alerts - a0),     64'(2));
        chk("t4_ch2_count",   64'(ch_alerts[2] - c0), 64'(2));

        // 5: reset mid-SCAN after "BOM" on ch1 wipes the context
        send_str(2'd1, "BOM");
        tb_byte[1]  = CH_B;
        tb_valid[0] = 1'b1;
        tb_byte[0]  = 8'h5A;
        rst         = 1'b1;
        #1;
        chk("t5_ready_in_rst", 64'(bus.req_ready), 64'(0));
        chk("t5_busy_scan",    64'(bus.busy),      64'(1));
        cycles(1);
        chk("t5_rst_grant", 64'(bus.grant), 64'(0));
        chk("t5_rst_alert", 64'(bus.alert), 64'(0));
        chk("t5_rst_busy",  64'(bus.busy),  64'(0));
        rst = 1'b0;
        cycles(1);
        chk("t5_grant_ch0", 64'(bus.grant), 64'(1));
        tb_valid[0] = 1'b0;
        a0 = n_alerts;
        send_byte(2'd1, CH_B);
        chk("t5_no_alert", 64'(bus.alert), 64'(0));
        tb_valid[1] = 1'b0;
        cycles(4);
        chk("t5_alert_count", 64'(n_alerts - a0), 64'(0));

`ifdef BSS_ALERT_CNT_EN
        // 6: counter saturation on ch3
        a0 = n_alerts;
        send_str(2'd3, "BOMB");
        cycles(1);
        chk("t6_acnt_first", 64'(bus.alert_cnt[31:24]), 64'(1));
        for (int n = 1; n < 300; n++) send_str(2'd3, "OMB");
        tb_valid[3] = 1'b0;
        cycles(4);
        chk("t6_alert_count", 64'(n_alerts - a0),         64'(300));
        chk("t6_acnt_ch3",    64'(bus.alert_cnt[31:24]),  64'(255));
        chk("t6_acnt_other",  64'(bus.alert_cnt[23:0]),   64'(0));
`else
        chk("t6_acnt_tied_off", 64'(bus.alert_cnt), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
